// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-flop input synchroniser, 3-sample majority bit decision, optional parity and stop checks.
// Latency: start tick 0 to result pulse = (1+DATA_WIDTH+PAR_EN)*OVERSAMPLE + OVERSAMPLE/2 + 2 cycles (plus 2 sync cycles).
// Backpressure: none; result pulses are single-cycle and RX_DATA holds the last good byte.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int H  = OVERSAMPLE / 2;

    localparam logic [TW-1:0] TICK_S0   = TW'(H - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(H);
    localparam logic [TW-1:0] TICK_DEC  = TW'(H + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] BITS_ALL  = CW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                r_state;
    state_t                w_nstate;
    logic [1:0]            r_sync;
    logic [TW-1:0]         r_tick;
    logic [1:0]            r_smp;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_bitcnt;
    logic                  r_pen;
    logic                  r_ptyp;
    logic                  r_perr;

    logic w_rxs;
    logic w_bit;
    logic w_dec;
    logic w_last;
    logic w_par_exp;
    logic w_dv;
    logic w_pe;
    logic w_se;

    assign w_rxs     = r_sync[1];
    // Majority of the two stored samples and the live sample at the decision tick.
    assign w_bit     = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rxs) | (r_smp[1] & w_rxs);
    assign w_dec     = (r_tick == TICK_DEC);
    assign w_last    = (r_tick == TICK_LAST);
    assign w_par_exp = r_ptyp ? ~^r_shift : ^r_shift;

    // Two-flop synchroniser; loads idle-high so reset release never looks like a start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_sync <= 2'b11;
        else      r_sync <= {r_sync[0], RX_IN};
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_nstate;
    end

    // Next-state decode and result-pulse generation.
    always_comb begin
        w_nstate = r_state;
        w_dv     = 1'b0;
        w_pe     = 1'b0;
        w_se     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_nstate = S_START;
            end
            S_START: begin
                // A start bit that votes high is a line glitch; a low vote stays to the end of the bit.
                if (w_dec && w_bit)  w_nstate = S_IDLE;
                else if (w_last)     w_nstate = S_DATA;
            end
            S_DATA: begin
                if (w_last && (r_bitcnt == BITS_ALL)) w_nstate = r_pen ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_last) w_nstate = S_STOP;
            end
            S_STOP: begin
                if (w_dec) begin
                    if (w_bit) begin
                        // Leave mid stop bit so a back-to-back start edge is caught on time.
                        w_nstate = S_IDLE;
                        w_dv     = ~r_perr;
                        w_pe     = r_perr;
                    end else begin
                        w_nstate = S_WAIT_HIGH;
                        w_se     = 1'b1;
                        w_pe     = r_perr;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (w_rxs) w_nstate = S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // Bit-period tick: the cycle IDLE first sees a low line is tick 0, so START begins at tick 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                  r_tick <= '0;
        else if (r_state == S_IDLE) r_tick <= w_rxs ? '0 : TW'(1);
        else                       r_tick <= r_tick + 1'b1;
    end

    // Capture the two early samples of each bit for the majority vote.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_smp <= 2'b11;
        end else begin
            if (r_tick == TICK_S0) r_smp[0] <= w_rxs;
            if (r_tick == TICK_S1) r_smp[1] <= w_rxs;
        end
    end

    // Frame datapath: config latch at start exit, LSB-first shift, parity verdict.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_pen    <= 1'b0;
            r_ptyp   <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            if ((r_state == S_START) && w_last) begin
                r_pen    <= PAR_EN;
                r_ptyp   <= PAR_TYP;
                r_perr   <= 1'b0;
                r_bitcnt <= '0;
            end
            if ((r_state == S_DATA) && w_dec) begin
                r_shift  <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            if ((r_state == S_PARITY) && w_dec) begin
                r_perr <= (w_bit != w_par_exp);
            end
        end
    end

    // Registered result outputs; RX_DATA only moves on a clean frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RX_DATA    <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= w_dv;
            PAR_ERR    <= w_pe;
            STP_ERR    <= w_se;
            if (w_dv) RX_DATA <= r_shift;
        end
    end

endmodule
